// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller with ALU-control decode, memory wait/timeout handling,
// sticky illegal-op / bus-error traps and a retired-instruction counter.
module mips_multicycle_ctrl #(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int ALUCTL_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [CNT_W-1:0]    instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE_EX,
    S_RTYPE_WB, S_BEQ, S_ADDI_EX, S_ADDI_WB, S_JUMP, S_TRAP
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

  localparam int                WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int                TMO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO_LAST);

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q, bus_q;
  logic               set_illegal, set_bus, timeout_hit, retire;

  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LAST);
  // Every path back into FETCH comes from a completing instruction.
  assign retire      = (state_nxt == S_FETCH) && (state != S_FETCH);

  always_comb begin
    state_nxt     = state;
    set_illegal   = 1'b0;
    set_bus       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_ctl       = '0;
    if (!reset) begin
      alu_ctl = ALU_ADD;
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_DECODE;
          end else if (timeout_hit) begin
            state_nxt = S_TRAP;
            set_bus   = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          if (opcode == OP_LW || opcode == OP_SW) state_nxt = S_MEMADR;
          else if (opcode == OP_RTYPE)            state_nxt = S_RTYPE_EX;
          else if (opcode == OP_BEQ)              state_nxt = S_BEQ;
          else if (opcode == OP_ADDI)             state_nxt = S_ADDI_EX;
          else if (opcode == OP_J)                state_nxt = S_JUMP;
          else begin
            state_nxt   = S_TRAP;
            set_illegal = 1'b1;
          end
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD, S_MEMWR: begin
          iord      = 1'b1;
          mem_read  = (state == S_MEMRD);
          mem_write = (state == S_MEMWR);
          if (mem_ready) state_nxt = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
          else if (timeout_hit) begin
            state_nxt = S_TRAP;
            set_bus   = 1'b1;
          end
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_RTYPE_EX: begin
          alu_src_a = 1'b1;
          state_nxt = S_RTYPE_WB;
          case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: begin
              state_nxt   = S_TRAP;
              set_illegal = 1'b1;
            end
          endcase
        end
        S_RTYPE_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          state_nxt = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          alu_ctl       = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          state_nxt     = S_FETCH;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_nxt = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          state_nxt = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_src    = 2'b10;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Staying put in a wait state only happens while memory is not ready.
      if (state_nxt != state) wait_cnt <= '0;
      else if (!mem_ready)    wait_cnt <= wait_cnt + WAIT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus)     bus_q     <= 1'b1;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign illegal_op    = illegal_q & ~reset;
  assign bus_error     = bus_q & ~reset;
  assign instr_retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle control-word checks with
// hand-computed expectations, traps, timeout, reset and counter wrap (CNT_W=2).
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctl;
  logic       illegal_op, bus_error;
  logic [1:0] instr_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OP_W(6), .FUNCT_W(6), .ALUCTL_W(3), .MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_ctl(alu_ctl), .illegal_op(illegal_op), .bus_error(bus_error),
    .instr_retired(instr_retired)
  );

  // Order: pc_write pc_write_cond iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b pc_src alu_ctl
  logic [16:0] ctl;
  assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_ctl};

  localparam logic [16:0] E_ZERO = 17'b0;
  localparam logic [16:0] E_FW   = {10'b0001000000, 2'b01, 2'b00, 3'b010};
  localparam logic [16:0] E_FR   = {10'b1001010000, 2'b01, 2'b00, 3'b010};
  localparam logic [16:0] E_DEC  = {10'b0000000000, 2'b11, 2'b00, 3'b010};
  localparam logic [16:0] E_MA   = {10'b0000000001, 2'b10, 2'b00, 3'b010};
  localparam logic [16:0] E_MRD  = {10'b0011000000, 2'b00, 2'b00, 3'b010};
  localparam logic [16:0] E_MWB  = {10'b0000000110, 2'b00, 2'b00, 3'b010};
  localparam logic [16:0] E_MWR  = {10'b0010100000, 2'b00, 2'b00, 3'b010};
  localparam logic [16:0] E_RADD = {10'b0000000001, 2'b00, 2'b00, 3'b010};
  localparam logic [16:0] E_RSUB = {10'b0000000001, 2'b00, 2'b00, 3'b110};
  localparam logic [16:0] E_RAND = {10'b0000000001, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_ROR  = {10'b0000000001, 2'b00, 2'b00, 3'b001};
  localparam logic [16:0] E_RSLT = {10'b0000000001, 2'b00, 2'b00, 3'b111};
  localparam logic [16:0] E_RWB  = {10'b0000001010, 2'b00, 2'b00, 3'b010};
  localparam logic [16:0] E_BEQ  = {10'b0100000001, 2'b00, 2'b01, 3'b110};
  localparam logic [16:0] E_AEX  = {10'b0000000001, 2'b10, 2'b00, 3'b010};
  localparam logic [16:0] E_AWB  = {10'b0000000010, 2'b00, 2'b00, 3'b010};
  localparam logic [16:0] E_JMP  = {10'b1000000000, 2'b00, 2'b10, 3'b010};
  localparam logic [16:0] E_TRAP = {10'b0000000000, 2'b00, 2'b00, 3'b010};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply mem_ready, check the current state's control word, then advance one clock.
  task automatic step(input string tag, input logic rdy, input logic [16:0] exp);
    mem_ready = rdy;
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic ill, input logic bus, input logic [1:0] cnt);
    check({tag, "_ill"}, 32'(illegal_op), 32'(ill));
    check({tag, "_bus"}, 32'(bus_error), 32'(bus));
    check({tag, "_cnt"}, 32'(instr_retired), 32'(cnt));
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check({tag, "_ctl_pre"}, 32'(ctl), 32'(E_ZERO));
    @(posedge clk);
    #1;
    check({tag, "_ctl"}, 32'(ctl), 32'(E_ZERO));
    flags(tag, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b0; funct = 6'b0;
    @(posedge clk); #1;
    do_reset("rst0");

    // lw: 5 cycles, reg_write only in the last
    set_op(6'b100011, 6'b0);
    step("lw_f", 1, E_FR); step("lw_d", 1, E_DEC); step("lw_ma", 1, E_MA);
    step("lw_rd", 1, E_MRD); step("lw_wb", 1, E_MWB);
    flags("lw", 1'b0, 1'b0, 2'd1);

    // sw with one wait cycle in MEMWR
    set_op(6'b101011, 6'b0);
    step("sw_f", 1, E_FR); step("sw_d", 1, E_DEC); step("sw_ma", 1, E_MA);
    step("sw_w0", 0, E_MWR); step("sw_w1", 1, E_MWR);
    flags("sw", 1'b0, 1'b0, 2'd2);

    set_op(6'b000000, 6'b100000);
    step("add_f", 1, E_FR); step("add_d", 1, E_DEC); step("add_ex", 1, E_RADD); step("add_wb", 1, E_RWB);
    flags("add", 1'b0, 1'b0, 2'd3);

    set_op(6'b000000, 6'b100010);
    step("sub_f", 1, E_FR); step("sub_d", 1, E_DEC); step("sub_ex", 1, E_RSUB); step("sub_wb", 1, E_RWB);
    flags("wrap", 1'b0, 1'b0, 2'd0);

    set_op(6'b000100, 6'b0);
    step("beq_f", 1, E_FR); step("beq_d", 1, E_DEC); step("beq_ex", 1, E_BEQ);
    flags("beq", 1'b0, 1'b0, 2'd1);

    set_op(6'b000010, 6'b0);
    step("j_f", 1, E_FR); step("j_d", 1, E_DEC); step("j_ex", 1, E_JMP);
    flags("j", 1'b0, 1'b0, 2'd2);

    set_op(6'b001000, 6'b0);
    step("addi_f", 1, E_FR); step("addi_d", 1, E_DEC); step("addi_ex", 1, E_AEX); step("addi_wb", 1, E_AWB);
    flags("addi", 1'b0, 1'b0, 2'd3);

    // and: fetch waits 3 cycles, ready arrives on the 4th (last) cycle and wins
    set_op(6'b000000, 6'b100100);
    step("and_fw0", 0, E_FW); step("and_fw1", 0, E_FW); step("and_fw2", 0, E_FW);
    step("and_f", 1, E_FR); step("and_d", 1, E_DEC); step("and_ex", 1, E_RAND); step("and_wb", 1, E_RWB);
    flags("and", 1'b0, 1'b0, 2'd0);

    set_op(6'b000000, 6'b100101);
    step("or_f", 1, E_FR); step("or_d", 1, E_DEC); step("or_ex", 1, E_ROR); step("or_wb", 1, E_RWB);
    set_op(6'b000000, 6'b101010);
    step("slt_f", 1, E_FR); step("slt_d", 1, E_DEC); step("slt_ex", 1, E_RSLT); step("slt_wb", 1, E_RWB);
    flags("slt", 1'b0, 1'b0, 2'd2);

    // MEMRD timeout after 4 waiting cycles; no retire
    set_op(6'b100011, 6'b0);
    step("to_f", 1, E_FR); step("to_d", 1, E_DEC); step("to_ma", 1, E_MA);
    for (int i = 0; i < 4; i++) step("to_rd", 0, E_MRD);
    step("to_trap0", 1, E_TRAP); step("to_trap1", 1, E_TRAP);
    flags("to_rd", 1'b0, 1'b1, 2'd2);
    do_reset("rst1");

    // FETCH timeout
    for (int i = 0; i < 4; i++) step("tof_f", 0, E_FW);
    step("tof_trap", 1, E_TRAP);
    flags("tof", 1'b0, 1'b1, 2'd0);
    do_reset("rst2");

    // illegal opcode
    set_op(6'b111111, 6'b0);
    step("ilo_f", 1, E_FR); step("ilo_d", 1, E_DEC);
    step("ilo_trap0", 1, E_TRAP); step("ilo_trap1", 1, E_TRAP);
    flags("ilo", 1'b1, 1'b0, 2'd0);
    do_reset("rst3");

    // illegal funct: alu_ctl stays add in RTYPE_EX, then trap
    set_op(6'b000000, 6'b000111);
    step("ilf_f", 1, E_FR); step("ilf_d", 1, E_DEC); step("ilf_ex", 1, E_RADD);
    step("ilf_trap0", 1, E_TRAP); step("ilf_trap1", 1, E_TRAP);
    flags("ilf", 1'b1, 1'b0, 2'd0);
    do_reset("rst4");

    // reset pulsed mid-MEMRD abandons the lw, then a full lw retires
    set_op(6'b100011, 6'b0);
    step("rmid_f", 1, E_FR); step("rmid_d", 1, E_DEC); step("rmid_ma", 1, E_MA);
    step("rmid_rd", 0, E_MRD);
    do_reset("rst5");
    step("post_f", 1, E_FR); step("post_d", 1, E_DEC); step("post_ma", 1, E_MA);
    step("post_rd", 1, E_MRD); step("post_wb", 1, E_MWB);
    flags("post", 1'b0, 1'b0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
